nibble_serial_subtractor: RTL



---
 rtl/nibble_serial_subtractor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - nibble-serial a - b - borrow_in, LSB nibble first (optional SUB_SIGNED_OVF_EN)
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             overflow
`endif
);

  // WIDTH must be a multiple of 4 and at least 4; NIB is derived, never overridden.
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
`ifdef SUB_SIGNED_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Slice signals for the current nibble (subtrahend already inverted).
  logic [3:0] na, nb, g, p, sum;
  logic       c0, c1, c2, c3, c4;

  // 4-bit lookahead slice: A + ~B + carry, carry = ~borrow.
  always_comb begin
    na  = a_sh_q[3:0];
    nb  = ~b_sh_q[3:0];
    g   = na & nb;
    p   = na ^ nb;
    c0  = carry_q;
    c1  = g[0] | (p[0] & c0);
    c2  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
        | (p[3] & p[2] & p[1] & p[0] & c0);
    sum = p ^ {c3, c2, c1, c0};
  end

  // Next-state and datapath updates; operands shift right so the live nibble sits at [3:0].
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SUB_SIGNED_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          carry_d = ~borrow_in;
          a_sh_d  = a;
          b_sh_d  = b;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int n = 0; n < NIB; n++) begin
          if (idx_q == IDX_W'(n)) diff_d[n*4 +: 4] = sum;
        end
        carry_d = c4;
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        if (idx_q == LAST_IDX) begin
          state_d  = DONE;
          borrow_d = ~c4;
`ifdef SUB_SIGNED_OVF_EN
          ovf_d    = c3 ^ c4;
`endif
        end else begin
          idx_d = IDX_W'(idx_q + 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b1;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Status decoded straight from the state register.
  always_comb begin
    busy       = (state_q == RUN);
    done       = (state_q == DONE);
    diff       = diff_q;
    borrow_out = borrow_q;
`ifdef SUB_SIGNED_OVF_EN
    overflow   = ovf_q;
`endif
  end

endmodule
